data_mem_dma: RTL
=================

DATA_MEM_DMA -- requirements
Module: data_mem_dma

Interface
REQ-001 Parameter: ADDR_W, 8, address width; DataMem is 256 deep, and wrap-around is modulo 2^ADDR_W.
REQ-002 Clk  in  1  single clock; all state updates on posedge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Start  in  1  request a transfer; sampled only in IDLE.
REQ-005 Mode  in  1  0 = copy, 1 = fill (fill only with DMA_FILL_EN).
REQ-006 SrcAddr, DstAddr  in  ADDR_W  source and destination start addresses.
REQ-007 Length  in  8  byte count; 0 = empty transfer.
REQ-008 FillValue  in  8  byte written in fill mode.
REQ-009 Abort  in  1  cancel the active transfer.
REQ-010 CoreAddr, CoreDataIn  in  ADDR_W, 8  processor-side address and data.
REQ-011 CoreWriteEn  in  1  processor-side write enable.
REQ-012 CoreDataOut  out  8  combinational copy of MemDataOut.
REQ-013 CoreStall  out  1  high while Busy; the processor must hold.
REQ-014 MemAddress, MemDataIn  out  ADDR_W, 8  drive DataMem DataAddress and DataIn.
REQ-015 MemWriteEn  out  1  drives DataMem WriteEn.
REQ-016 MemDataOut  in  8  DataMem combinational read data.
REQ-017 Busy  out  1  high in READ, WRITE and DONE.
REQ-018 Done  out  1  one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, READ, WRITE and DONE.
REQ-020 In IDLE, MemAddress, MemDataIn and MemWriteEn SHALL pass through CoreAddr, CoreDataIn and CoreWriteEn combinationally.
REQ-021 IDLE with Start=1 and Abort=0 SHALL latch SrcAddr, DstAddr, Length, Mode and FillValue, then go to:
- DONE if Length=0;
- WRITE in fill mode;
- READ otherwise.
REQ-022 After REQ-021, input changes SHALL have no effect until the next IDLE.
REQ-023 READ SHALL drive MemAddress=src with MemWriteEn=0, capture MemDataOut into a byte buffer at the edge, and go to WRITE.
REQ-024 WRITE SHALL drive MemAddress=dst, MemDataIn=buffer (FillValue in fill mode) and MemWriteEn=1, then at the edge:
- increment src and dst (wrap 0xFF->0x00);
- decrement count;
- go to DONE when count reaches 0; otherwise go to READ (copy) or stay in WRITE (fill).
REQ-025 Copy of N bytes SHALL take 2N cycles in READ/WRITE plus 1 DONE cycle; fill SHALL take N+1 cycles.
REQ-026 DONE SHALL assert Done=1 for exactly one cycle, then return to IDLE; Start in DONE SHALL be ignored.
REQ-027 While Busy, Core* inputs SHALL be ignored, no processor write SHALL reach memory, and CoreStall SHALL be 1.
REQ-028 Copying is strictly forward and byte-sequential.
- If dst is inside (src, src+N), already-written bytes are re-read; this propagated-pattern result is the defined behaviour.
REQ-029 Abort=1 in READ or WRITE SHALL suppress that cycle's MemWriteEn and go to IDLE at the edge with no Done pulse.
- Bytes already written stay written.
REQ-030 Abort in IDLE or DONE SHALL be ignored, except that Start+Abort in IDLE SHALL remain in IDLE.
REQ-031 Address wrap-around within one transfer SHALL be legal and silent.

Reset
REQ-032 Reset=0 SHALL immediately force state=IDLE, Busy=0, Done=0 and CoreStall=0, and clear count, buffer and address registers to 0.
REQ-033 While Reset=0, MemWriteEn SHALL be 0 regardless of CoreWriteEn.
REQ-034 Reset during a transfer SHALL abandon it with no Done pulse; bytes already written stay written.
REQ-035 After Reset deasserts, the first Start SHALL be accepted on the first posedge.

Configuration
REQ-036 Macro DMA_FILL_EN defined: Mode=1 SHALL select fill per REQ-021/REQ-024.
REQ-037 Macro DMA_FILL_EN undefined: Mode and FillValue SHALL be ignored, every transfer SHALL be a copy, and no fill logic SHALL be synthesized.

Verification
REQ-038 Copy: Src=0x00, Dst=0x80, Len=4, mem[0..3]=52,03,E6,05 -> mem[80..83] match; Done on cycle 9 after the Start edge; CoreStall high for 9 cycles.
REQ-039 Len=0: Start -> DONE next cycle, Done pulse, no MemWriteEn ever asserted.
REQ-040 Wrap: Src=0xFE, Dst=0x10, Len=3 -> mem[10..12] = mem[FE], mem[FF], mem[00].
REQ-041 Abort: Len=6, Abort asserted in the third WRITE -> exactly 2 bytes written, no Done, IDLE next cycle.
REQ-042 Reset: Reset=0 mid-transfer -> Busy=0 and MemWriteEn=0 immediately; a following Start with Len=1 completes normally.
REQ-043 Fill (DMA_FILL_EN defined): Dst=0x40, Len=5, FillValue=0xAA -> mem[40..44]=AA, Done at cycle 6; with the macro undefined, the same stimulus performs a copy.

Source files
------------

// File: rtl/data_mem_dma.sv
// data_mem_dma: byte-sequential DMA copy engine sharing DataMem with the processor port.
// Optional fill mode is built in only when the DMA_FILL_EN macro is defined.
module data_mem_dma #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [7:0]        Length,
  input  logic [7:0]        FillValue,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] CoreAddr,
  input  logic [7:0]        CoreDataIn,
  input  logic              CoreWriteEn,
  output logic [7:0]        CoreDataOut,
  output logic              CoreStall,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        MemDataIn,
  output logic              MemWriteEn,
  input  logic [7:0]        MemDataOut,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dmaState_t;

  dmaState_t         state, nextState;
  logic [ADDR_W-1:0] src, dst;
  logic [7:0]        count;
  logic [7:0]        buffer;
  logic              startFill;
  logic              activeFill;
  logic [7:0]        writeData;

`ifdef DMA_FILL_EN
  logic       fillMode;
  logic [7:0] fillVal;

  assign startFill  = Mode;
  assign activeFill = fillMode;
  assign writeData  = fillMode ? fillVal : buffer;
`else
  logic unusedFill;

  // Copy-only build: the fill controls are deliberately left unconnected.
  assign unusedFill = ^{Mode, FillValue};
  assign startFill  = 1'b0;
  assign activeFill = 1'b0;
  assign writeData  = buffer;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (Start && !Abort) begin
          if (Length == 8'd0)  nextState = DONE;
          else if (startFill)  nextState = WRITE;
          else                 nextState = READ;
        end
      end
      READ:  nextState = Abort ? IDLE : WRITE;
      WRITE: begin
        if (Abort)                nextState = IDLE;
        else if (count == 8'd1)   nextState = DONE;
        else if (activeFill)      nextState = WRITE;
        else                      nextState = READ;
      end
      DONE:  nextState = IDLE;
    endcase
  end

  // Memory port belongs to the processor only in IDLE; otherwise the engine owns it.
  always_comb begin
    MemAddress = CoreAddr;
    MemDataIn  = CoreDataIn;
    MemWriteEn = 1'b0;
    unique case (state)
      IDLE: MemWriteEn = CoreWriteEn & Reset;
      READ: begin
        MemAddress = src;
        MemDataIn  = buffer;
      end
      WRITE: begin
        MemAddress = dst;
        MemDataIn  = writeData;
        MemWriteEn = ~Abort;
      end
      DONE: begin
        MemAddress = dst;
        MemDataIn  = buffer;
      end
    endcase
  end

  assign Busy        = (state != IDLE);
  assign CoreStall   = Busy;
  assign Done        = (state == DONE);
  assign CoreDataOut = MemDataOut;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      src    <= '0;
      dst    <= '0;
      count  <= '0;
      buffer <= '0;
`ifdef DMA_FILL_EN
      fillMode <= 1'b0;
      fillVal  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Abort) begin
            src   <= SrcAddr;
            dst   <= DstAddr;
            count <= Length;
`ifdef DMA_FILL_EN
            fillMode <= Mode;
            fillVal  <= FillValue;
`endif
          end
        end
        READ: begin
          if (!Abort) buffer <= MemDataOut;
        end
        WRITE: begin
          if (!Abort) begin
            src   <= src + ADDR_W'(1);
            dst   <= dst + ADDR_W'(1);
            count <= count - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
